// File: rtl/boxcar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boxcar_pkg
//  Description : Shared types and constants for the boxcar integrator:
//                FSM state encoding, the len_log2 port width and a helper
//                that clamps a requested window exponent to the buffer depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package boxcar_pkg;

  // Width of the len_log2 port (window exponent 0..15 before clamping)
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // Requested window exponents beyond the buffer depth saturate at the depth
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req,
                                                 input logic [LEN_W-1:0] max_len);
    return (req > max_len) ? max_len : req;
  endfunction

endpackage : boxcar_pkg
`default_nettype wire

// File: rtl/boxcar_ring_buf.sv
`default_nettype none
// ============================================================================
//  Module      : boxcar_ring_buf
//  Description : Sample history storage, 2^ADDR_WIDTH x DATA_WIDTH.
//                One synchronous write port, one combinational read port.
//                Contents are not reset; the owner zeroes it by sweeping.
//  Ports       : clk   - clock
//                we    - write enable
//                waddr - write address
//                wdata - write data
//                raddr - read address
//                rdata - read data (combinational, returns pre-write value)
//  Revision    : 1.0 - initial release
// ============================================================================
module boxcar_ring_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : boxcar_ring_buf
`default_nettype wire

// File: rtl/boxcar_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : boxcar_integrator
//  Description : Moving-window (boxcar) sum / average over the last
//                2^len_q accepted samples, using a ring buffer and a running
//                sum updated by (new - oldest) on every accepted sample.
//                Build option BOXCAR_SAT_EN: running-sum output (mode=1)
//                saturates to the DATA_WIDTH range instead of wrapping.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                en        - sample strobe (honoured only when in_ready=1)
//                in        - signed input sample
//                clr       - synchronous flush request
//                mode      - 0: average output, 1: running-sum output
//                len_log2  - window exponent, sampled only while clearing
//                in_ready  - high when a sample can be accepted
//                out       - registered signed result
//                out_valid - one-cycle pulse after each accepted sample
//                primed    - a full window has been accepted since flush
//  Revision    : 1.0 - initial release
// ============================================================================
module boxcar_integrator
  import boxcar_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] in,
  input  logic                         clr,
  input  logic                         mode,
  input  logic        [LEN_W-1:0]      len_log2,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_valid,
  output logic                         primed
);

  localparam int c_depth = 2 ** LOG2_DEPTH;
  localparam int c_ptr_w = LOG2_DEPTH;
  localparam int c_cnt_w = LOG2_DEPTH + 1;
  localparam int c_sum_w = DATA_WIDTH + LOG2_DEPTH;
  localparam logic [LEN_W-1:0]   c_max_len  = LEN_W'(LOG2_DEPTH);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(c_depth - 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic        [c_ptr_w-1:0]   r_ptr;
  logic signed [c_sum_w-1:0]   r_sum;
  logic        [c_cnt_w-1:0]   r_count;
  logic        [LEN_W-1:0]     r_len_q;
  logic signed [DATA_WIDTH-1:0] r_out;
  logic                        r_out_valid;
  logic                        r_primed;

  logic                        w_accept;
  logic        [c_cnt_w-1:0]   w_win;
  logic        [c_ptr_w-1:0]   w_rd_addr;
  logic        [DATA_WIDTH-1:0] w_oldest;
  logic                        w_buf_we;
  logic        [DATA_WIDTH-1:0] w_buf_wdata;
  logic signed [c_sum_w-1:0]   w_in_ext;
  logic signed [c_sum_w-1:0]   w_old_ext;
  logic signed [c_sum_w-1:0]   w_sum_next;
  logic signed [c_sum_w-1:0]   w_avg;
  logic        [DATA_WIDTH-1:0] w_sum_out;
  logic                        w_window_full;

  assign in_ready = (r_state != S_CLEAR);
  // A flush in the same cycle discards the sample entirely
  assign w_accept = en & in_ready & ~clr;

  assign w_win = c_cnt_w'(1) << r_len_q;
  // When the window spans the whole buffer the low bits of w_win are zero,
  // so the oldest sample is the entry about to be overwritten (read first).
  assign w_rd_addr = r_ptr - w_win[c_ptr_w-1:0];

  assign w_buf_we    = (r_state == S_CLEAR) | w_accept;
  assign w_buf_wdata = (r_state == S_CLEAR) ? '0 : in;

  boxcar_ring_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (c_ptr_w)
  ) u_ring_buf (
    .clk   (clk),
    .we    (w_buf_we),
    .waddr (r_ptr),
    .wdata (w_buf_wdata),
    .raddr (w_rd_addr),
    .rdata (w_oldest)
  );

  // Sum width covers DEPTH full-scale samples, so modular arithmetic at this
  // width always yields the exact window sum.
  assign w_in_ext   = {{(c_sum_w-DATA_WIDTH){in[DATA_WIDTH-1]}}, in};
  assign w_old_ext  = {{(c_sum_w-DATA_WIDTH){w_oldest[DATA_WIDTH-1]}}, w_oldest};
  assign w_sum_next = r_sum + w_in_ext - w_old_ext;
  assign w_avg      = w_sum_next >>> r_len_q;

`ifdef BOXCAR_SAT_EN
  logic w_ovf;
  // Overflow when the bits above the output sign bit are not a pure sign run
  assign w_ovf = (|w_sum_next[c_sum_w-1:DATA_WIDTH-1]) &
                 ~(&w_sum_next[c_sum_w-1:DATA_WIDTH-1]);
  assign w_sum_out = !w_ovf ? w_sum_next[DATA_WIDTH-1:0] :
                     w_sum_next[c_sum_w-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                             {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  assign w_sum_out = w_sum_next[DATA_WIDTH-1:0];
`endif

  assign w_window_full = ((r_count + c_cnt_w'(1)) == w_win);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (r_ptr == c_last_ptr) w_state_next = S_FILL;
      S_FILL:  if (w_accept && w_window_full) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_CLEAR;
    endcase
    if (clr) begin
      w_state_next = S_CLEAR;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_len_q     <= c_max_len;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_primed    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      // Window length is latched only while clearing, so it cannot change
      // underneath a populated history.
      if (r_state == S_CLEAR) begin
        r_len_q <= clamp_len(len_log2, c_max_len);
      end
      if (clr) begin
        r_ptr    <= '0;
        r_sum    <= '0;
        r_count  <= '0;
        r_primed <= 1'b0;
      end else if (r_state == S_CLEAR) begin
        r_ptr   <= r_ptr + c_ptr_w'(1);
        r_sum   <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        r_ptr       <= r_ptr + c_ptr_w'(1);
        r_sum       <= w_sum_next;
        r_out       <= mode ? w_sum_out : w_avg[DATA_WIDTH-1:0];
        r_out_valid <= 1'b1;
        if (r_state == S_FILL) begin
          r_count <= r_count + c_cnt_w'(1);
          if (w_window_full) begin
            r_primed <= 1'b1;
          end
        end
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign primed    = r_primed;

endmodule : boxcar_integrator
`default_nettype wire

// File: tb/tb_boxcar_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boxcar_integrator
//  Description : Self-checking bench for boxcar_integrator (16-bit, depth 8).
//                A sample-history model predicts every output each cycle;
//                literal expectations pin known sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_boxcar_integrator;

  localparam int DW    = 16;
  localparam int LD    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] in_s = '0;
  logic [3:0]    len_log2 = 4'd3;
  logic          in_ready;
  logic          out_valid;
  logic          primed;
  logic [DW-1:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  boxcar_integrator #(
    .DATA_WIDTH (DW),
    .LOG2_DEPTH (LD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in        (in_s),
    .clr       (clr),
    .mode      (mode),
    .len_log2  (len_log2),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_clear_left;
  int            m_len;
  int            m_hist[$];
  bit            m_primed;
  bit            m_valid;
  logic [DW-1:0] m_out;
  bit            m_ready;

  // Result from the plain window sum of the most recent 2^L samples
  function automatic logic [DW-1:0] model_result(input int L, input bit md);
    longint     s = 0;
    int         n = 1 << L;
    logic [63:0] t;
    for (int k = 0; k < n && k < m_hist.size(); k++)
      s += m_hist[m_hist.size() - 1 - k];
    if (!md) begin
      t = s >>> L;
    end else begin
`ifdef BOXCAR_SAT_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`endif
      t = s;
    end
    return t[DW-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear_left = DEPTH;
      m_len        = LD;
      m_hist.delete();
      m_primed     = 1'b0;
      m_valid      = 1'b0;
      m_out        = '0;
    end else begin
      m_ready = (m_clear_left == 0);
      if (!m_ready) m_len = (int'(len_log2) > LD) ? LD : int'(len_log2);
      m_valid = 1'b0;
      if (clr) begin
        m_clear_left = DEPTH;
        m_hist.delete();
        m_primed = 1'b0;
      end else if (!m_ready) begin
        m_clear_left--;
      end else if (en) begin
        m_hist.push_back(int'($signed(in_s)));
        if (m_hist.size() > 64) void'(m_hist.pop_front());
        m_out   = model_result(m_len, mode);
        m_valid = 1'b1;
        if (m_hist.size() >= (1 << m_len)) m_primed = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("in_ready", longint'(in_ready), longint'(m_clear_left == 0));
      check("out_valid", longint'(out_valid), longint'(m_valid));
      check("primed", longint'(primed), longint'(m_primed));
      check("out", longint'($signed(out)), longint'($signed(m_out)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic accept(input int v);
    @(negedge clk);
    en   = 1'b1;
    in_s = v[DW-1:0];
    @(negedge clk);
    en   = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic flush(input logic [3:0] len);
    int n;
    @(negedge clk);
    clr      = 1'b1;
    len_log2 = len;
    @(negedge clk);
    clr = 1'b0;
    wait_ready(n);
    check("flush_cycles", n, 8);
  endtask

  task automatic seq_avg4();
    mode = 1'b0;
    accept(4);  check("avg4_a", longint'($signed(out)), 1);  check("avg4_pa", primed, 0);
    accept(8);  check("avg4_b", longint'($signed(out)), 3);
    accept(12); check("avg4_c", longint'($signed(out)), 6);  check("avg4_pc", primed, 0);
    accept(16); check("avg4_d", longint'($signed(out)), 10); check("avg4_pd", primed, 1);
    accept(20); check("avg4_e", longint'($signed(out)), 14);
  endtask

  initial begin
    int n;
    int r;
    longint exp_sum;

    // Reset state
    len_log2 = 4'd2;
    repeat (3) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_primed", primed, 0);
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    wait_ready(n);
    check("clear_cycles", n, 8);

    // Window 4 averaging
    seq_avg4();

    // Window 2, negative floor
    flush(4'd1);
    accept(-3); check("floor_a", longint'($signed(out)), -2);
    accept(-4); check("floor_b", longint'($signed(out)), -4);

    // Window 8 running sum (request 9 clamps to 3)
    flush(4'd9);
    mode = 1'b1;
    repeat (8) accept(32767);
`ifdef BOXCAR_SAT_EN
    exp_sum = 64'h7FFF;
`else
    exp_sum = 64'hFFF8;
`endif
    check("sum_full", out, exp_sum);
    check("sum_primed", primed, 1);

    // Flush wins over a simultaneous sample
    @(negedge clk);
    clr = 1'b1; en = 1'b1; in_s = 16'd123; len_log2 = 4'd0;
    @(negedge clk);
    clr = 1'b0; en = 1'b0;
    check("clr_no_valid", out_valid, 0);
    check("clr_out_hold", out, exp_sum);
    check("clr_primed", primed, 0);
    wait_ready(n);
    check("clr_cycles", n, 8);
    mode = 1'b0;
    accept(5);  check("win1_a", longint'($signed(out)), 5);
    accept(-7); check("win1_b", longint'($signed(out)), -7);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r        = int'($urandom_range(0, 99));
      clr      = (r < 2);
      en       = 1'($urandom_range(0, 1));
      mode     = 1'($urandom_range(0, 1));
      len_log2 = 4'($urandom_range(0, 15));
      if (r > 90)      in_s = (r[0]) ? 16'h7FFF : 16'h8000;
      else             in_s = 16'($urandom);
    end
    @(negedge clk);
    clr = 1'b0; en = 1'b0;

    // Reset in the middle of a run behaves like power-on
    flush(4'd2);
    mode = 1'b1;
    repeat (5) accept(int'($urandom_range(0, 1000)));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_primed", primed, 0);
    check("mid_rst_ready", in_ready, 0);
    len_log2 = 4'd2;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    check("mid_rst_clear", n, 8);
    seq_avg4();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_boxcar_integrator
`default_nettype wire

// File: doc/boxcar_integrator.md
BOXCAR_INTEGRATOR -- requirements
Module: boxcar_integrator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample and output width, two's complement.
REQ-002 SHALL have parameter LOG2_DEPTH, default 3: ring-buffer depth DEPTH = 2^LOG2_DEPTH, legal range 1..8.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  sample strobe; accepted only when in_ready=1.
REQ-006 SHALL have port in  input  DATA_WIDTH  signed input sample.
REQ-007 SHALL have port clr  input  1  synchronous flush request.
REQ-008 SHALL have port mode  input  1  0 = average output, 1 = running-sum output.
REQ-009 SHALL have port len_log2  input  4  window length is 2^len_log2; values above LOG2_DEPTH clamp to LOG2_DEPTH.
REQ-010 SHALL have port in_ready  output  1  high when a sample can be accepted.
REQ-011 SHALL have port out  output  DATA_WIDTH  signed registered result.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse, cycle after an accepted sample.
REQ-013 SHALL have port primed  output  1  high once a full window has been accepted since the last flush.

Function
REQ-014 SHALL implement FSM states CLEAR, FILL, RUN.
REQ-015 CLEAR: in_ready=0; writes zero to buffer entry ptr, ptr 0..DEPTH-1, one per cycle; after DEPTH cycles -> FILL with ptr=0, sum=0, count=0.
REQ-016 SHALL reload internal len_q from clamped len_log2 every CLEAR cycle and hold it in FILL/RUN; len_log2 changes outside CLEAR take no effect.
REQ-017 Accepted sample (en & in_ready): oldest = buf[(ptr - 2^len_q) mod DEPTH], read before write; sum <= sum + in - oldest; buf[ptr] <= in; ptr increments mod DEPTH.
REQ-018 sum SHALL be DATA_WIDTH+LOG2_DEPTH bits signed; never overflows.
REQ-019 mode=0: out <= sum_next >>> len_q (arithmetic shift, floor toward minus infinity).
REQ-020 mode=1: out <= sum_next reduced to DATA_WIDTH per REQ-030/031.
REQ-021 out and out_valid SHALL update one cycle after acceptance (latency 1); out holds between accepts.
REQ-022 FILL -> RUN, primed=1, on the accept that makes count reach 2^len_q; primed stays 1 until flush; before priming, unwritten entries contribute zero.
REQ-023 clr in any state -> CLEAR next cycle; ptr=0, sum=0, primed=0, out_valid=0; out holds last value.
REQ-024 clr and en same cycle: clr wins, sample discarded, no out_valid.
REQ-025 en while in_ready=0 SHALL be ignored with no state change.
REQ-026 len_q=0: out equals in (window 1).

Reset
REQ-027 rst_n low SHALL asynchronously force state=CLEAR, ptr=0, sum=0, count=0, len_q=LOG2_DEPTH, out=0, out_valid=0, primed=0.
REQ-028 Buffer SHALL not be reset directly; zeroed by the CLEAR sweep after reset release.
REQ-029 Reset mid-FILL/RUN SHALL discard all history; behaviour identical to power-on.

Configuration
REQ-030 With BOXCAR_SAT_EN defined: mode=1 output saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-031 Without BOXCAR_SAT_EN: mode=1 output is low DATA_WIDTH bits of sum (wrap); mode=0 unaffected either way.

Structure
REQ-032 Package boxcar_pkg SHALL hold the FSM state enum and the len_log2 port width constant.
REQ-033 Buffer SHALL be sub-module boxcar_ring_buf (DEPTH x DATA_WIDTH, one write port, one combinational read port, no reset).

Verification (DATA_WIDTH=16, LOG2_DEPTH=3)
REQ-034 Release reset -> in_ready=0 for 8 cycles then 1; out=0, primed=0.
REQ-035 len_log2=2, mode=0, accept 4,8,12,16,20 -> out 1,3,6,10,14; primed rises with the 10.
REQ-036 len_log2=1, mode=0, accept -3,-4 -> out -2,-4 (floor).
REQ-037 len_log2=3, mode=1, accept 8 x 32767 -> final out 0x7FFF with BOXCAR_SAT_EN, 0xFFF8 without.
REQ-038 RUN, assert clr with en=1 -> no out_valid, in_ready=0 for 8 cycles, next accept of 5 with len_log2=0 -> out 5.
REQ-039 Assert rst_n low mid-RUN -> all outputs 0 immediately; post-CLEAR results match fresh start.
